// File: rtl/mips_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_issue_ctrl
// Purpose  : Initiator side of the MIPSALU interface. Accepts a decoded ALU
//            request (ALUOp + funct + operands) over a valid/ready handshake,
//            generates the 4-bit ALU control code, drives the combinational
//            ALU, waits EXEC_CYCLES clocks for it to settle, then captures
//            ALUOut/Zero and returns them over a valid/ready response channel.
// Ports    : clk, rst_n                 clock, async active-low reset
//            req_valid/req_ready        request handshake
//            req_aluop/req_funct        decoded ALUOp and R-type funct
//            req_a/req_b                operands
//            alu_ctl/alu_a/alu_b        drive to the ALU (held between ops)
//            alu_out/alu_zero           ALU results
//            rsp_valid/rsp_ready        response handshake
//            rsp_result/rsp_zero        captured result (0 / 1 when illegal)
//            rsp_illegal                request used an unsupported code
//            op_count                   responses accepted since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_issue_ctrl #(
    parameter int LEN         = 32,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [LEN-1:0]   req_a,
    input  logic [LEN-1:0]   req_b,
    output logic [3:0]       alu_ctl,
    output logic [LEN-1:0]   alu_a,
    output logic [LEN-1:0]   alu_b,
    input  logic [LEN-1:0]   alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [LEN-1:0]   rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count
);

    // Settle counter is loaded with EXEC_CYCLES-1 and counts down to 0.
    localparam logic [3:0] c_SETTLE_LOAD = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_illegal;
    logic              r_req_ready;
    logic [3:0]        r_alu_ctl;
    logic [LEN-1:0]    r_alu_a;
    logic [LEN-1:0]    r_alu_b;
    logic              r_rsp_valid;
    logic [LEN-1:0]    r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_illegal;
    logic [CNT_W-1:0]  r_op_count;

    logic [3:0]        w_ctl;
    logic              w_illegal;

    // ------------------------------------------------------------------------
    // ALU control decode from the live request; only registered at accept.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ctl     = 4'd0;
        w_illegal = 1'b0;
        case (req_aluop)
            2'b00: w_ctl = 4'd2;
            2'b01: w_ctl = 4'd6;
            2'b10: begin
                case (req_funct)
                    6'b100000: w_ctl = 4'd2;   // add
                    6'b100010: w_ctl = 4'd6;   // sub
                    6'b100100: w_ctl = 4'd0;   // and
                    6'b100101: w_ctl = 4'd1;   // or
                    6'b101010: w_ctl = 4'd7;   // slt
                    6'b100111: w_ctl = 4'd12;  // nor
                    default:   w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM. The response becomes valid one clock after capture, so the
    // first RESP cycle only raises rsp_valid; handshakes are taken afterwards.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_illegal     <= 1'b0;
            r_req_ready   <= 1'b0;
            r_alu_ctl     <= 4'd0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_op_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_alu_ctl   <= w_ctl;
                        r_alu_a     <= req_a;
                        r_alu_b     <= req_b;
                        r_illegal   <= w_illegal;
                        r_cnt       <= c_SETTLE_LOAD;
                        r_req_ready <= 1'b0;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        // Illegal ops never expose whatever the ALU produced.
                        r_rsp_result  <= r_illegal ? '0 : alu_out;
                        r_rsp_zero    <= r_illegal ? 1'b1 : alu_zero;
                        r_rsp_illegal <= r_illegal;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign alu_ctl     = r_alu_ctl;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;
    assign op_count    = r_op_count;

endmodule
`default_nettype wire
